// File: rtl/tpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tpu_pkg                                                  |
// | Description : Shared constants, FSM state type and window helpers for |
// |               the TPU sequence controller.                             |
// | Contents    : ARRAY_SIZE, DATA_W/ACC_W/RES_W data widths,              |
// |               RADDR_W/WADDR_W SRAM address widths, tpu_state_e,        |
// |               lag_addr()/in_window() feed-window helpers.              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package tpu_pkg;

  localparam int ARRAY_SIZE   = 8;
  localparam int DATA_W       = 8;
  localparam int ACC_W        = 2 * DATA_W;          // 16
  localparam int RES_W        = ARRAY_SIZE * ACC_W;  // 128, one anti-diagonal
  localparam int RADDR_W      = 10;
  localparam int WADDR_W      = 6;
  localparam int NUM_RES_SRAM = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } tpu_state_e;

  // True while feed counter cnt lies inside a group's window [lag, lag+span).
  function automatic logic in_window(input int unsigned cnt,
                                     input int unsigned lag,
                                     input int unsigned span);
    return (cnt >= lag) && (cnt < lag + span);
  endfunction

  // Read address for a group lagging by 'lag' cycles; parks at 0 outside window.
  function automatic logic [RADDR_W-1:0] lag_addr(input int unsigned cnt,
                                                  input int unsigned lag,
                                                  input int unsigned span);
    if (in_window(cnt, lag, span)) begin
      return RADDR_W'(cnt - lag);
    end
    return '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_seq_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tpu_seq_ctrl_if                                          |
// | Description : Bus bundle between the TPU sequence controller and its  |
// |               environment (operand SRAMs, array, result SRAMs, host). |
// | Modports    : master - controller side (drives addresses/strobes)      |
// |               slave  - environment side (drives start and results)     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface tpu_seq_ctrl_if;
  import tpu_pkg::*;

  // host control
  logic               tpu_start;
  logic               tpu_done;
  logic               busy;
  logic               err;
  // operand feed
  logic [RADDR_W-1:0] sram_raddr_w0;
  logic [RADDR_W-1:0] sram_raddr_w1;
  logic [RADDR_W-1:0] sram_raddr_d0;
  logic [RADDR_W-1:0] sram_raddr_d1;
  logic               feed_valid0;
  logic               feed_valid1;
  logic               array_clear;
  // result path
  logic               res_valid;
  logic [RES_W-1:0]   res_data;
  logic               sram_write_enable_a0;
  logic               sram_write_enable_b0;
  logic               sram_write_enable_c0;
  logic [RES_W-1:0]   sram_wdata_a;
  logic [RES_W-1:0]   sram_wdata_b;
  logic [RES_W-1:0]   sram_wdata_c;
  logic [WADDR_W-1:0] sram_waddr_a;
  logic [WADDR_W-1:0] sram_waddr_b;
  logic [WADDR_W-1:0] sram_waddr_c;

  modport master (
    input  tpu_start, res_valid, res_data,
    output tpu_done, busy, err,
    output sram_raddr_w0, sram_raddr_w1, sram_raddr_d0, sram_raddr_d1,
    output feed_valid0, feed_valid1, array_clear,
    output sram_write_enable_a0, sram_write_enable_b0, sram_write_enable_c0,
    output sram_wdata_a, sram_wdata_b, sram_wdata_c,
    output sram_waddr_a, sram_waddr_b, sram_waddr_c
  );

  modport slave (
    output tpu_start, res_valid, res_data,
    input  tpu_done, busy, err,
    input  sram_raddr_w0, sram_raddr_w1, sram_raddr_d0, sram_raddr_d1,
    input  feed_valid0, feed_valid1, array_clear,
    input  sram_write_enable_a0, sram_write_enable_b0, sram_write_enable_c0,
    input  sram_wdata_a, sram_wdata_b, sram_wdata_c,
    input  sram_waddr_a, sram_waddr_b, sram_waddr_c
  );

endinterface
`default_nettype wire

// File: rtl/tpu_wb_router.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tpu_wb_router                                            |
// | Description : Counts accepted result words and routes each one to the |
// |               result SRAM of its batch with a registered active-low   |
// |               write strobe, address and data.                          |
// | Ports       : clk, srstn    - clock, async active-low reset            |
// |               active        - run in progress (FEED/WAIT)              |
// |               res_valid/res_data - result word from the array          |
// |               wb_done       - all batch results written                |
// |               wsb/waddr/wdata - per-SRAM strobe, address, data         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tpu_wb_router #(
  parameter int ARRAY_SIZE = 8,
  parameter int BATCHES    = 3
) (
  input  logic                                               clk,
  input  logic                                               srstn,
  input  logic                                               active,
  input  logic                                               res_valid,
  input  logic [tpu_pkg::RES_W-1:0]                          res_data,
  output logic                                               wb_done,
  output logic [tpu_pkg::NUM_RES_SRAM-1:0]                   wsb,
  output logic [tpu_pkg::NUM_RES_SRAM-1:0][tpu_pkg::WADDR_W-1:0] waddr,
  output logic [tpu_pkg::NUM_RES_SRAM-1:0][tpu_pkg::RES_W-1:0]   wdata
);
  import tpu_pkg::*;

  // Each batch yields 2*N-1 anti-diagonal words.
  localparam int c_diag    = 2 * ARRAY_SIZE - 1;
  localparam int c_total   = BATCHES * c_diag;
  localparam int c_wb_w    = $clog2(c_total + 1);
  localparam int c_batch_w = $clog2(NUM_RES_SRAM);

  logic [c_wb_w-1:0]    r_wb;
  logic [WADDR_W-1:0]   r_addr;   // wb % c_diag, tracked incrementally
  logic [c_batch_w-1:0] r_batch;  // wb / c_diag, tracked incrementally
  logic                 w_accept;

  logic [NUM_RES_SRAM-1:0]              r_wsb;
  logic [NUM_RES_SRAM-1:0][WADDR_W-1:0] r_waddr;
  logic [NUM_RES_SRAM-1:0][RES_W-1:0]   r_wdata;

  assign w_accept = active && res_valid && (r_wb != c_wb_w'(c_total));
  assign wb_done  = (r_wb == c_wb_w'(c_total));

  // Counters rest at zero whenever no run is active, so each run starts clean.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_wb    <= '0;
      r_addr  <= '0;
      r_batch <= '0;
    end else if (!active) begin
      r_wb    <= '0;
      r_addr  <= '0;
      r_batch <= '0;
    end else if (w_accept) begin
      r_wb <= r_wb + 1'b1;
      if (r_addr == WADDR_W'(c_diag - 1)) begin
        r_addr  <= '0;
        r_batch <= r_batch + 1'b1;
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Only the selected SRAM sees its strobe low; address/data of the others hold.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_wsb   <= '1;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      for (int i = 0; i < NUM_RES_SRAM; i++) begin
        if (w_accept && (r_batch == c_batch_w'(i))) begin
          r_wsb[i]   <= 1'b0;
          r_waddr[i] <= r_addr;
          r_wdata[i] <= res_data;
        end else begin
          r_wsb[i] <= 1'b1;
        end
      end
    end
  end

  assign wsb   = r_wsb;
  assign waddr = r_waddr;
  assign wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/tpu_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tpu_seq_ctrl                                             |
// | Description : Sequencer for a systolic-array TPU: streams operand SRAM |
// |               read addresses for two lagged row groups, flags operand |
// |               validity, clears the accumulators, and writes the       |
// |               anti-diagonal results back to three result SRAMs.       |
// | Ports       : clk   - clock                                            |
// |               srstn - asynchronous active-low reset                    |
// |               bus   - tpu_seq_ctrl_if.master (start/done/busy/err,     |
// |                       operand read addresses, feed_valid0/1,           |
// |                       array_clear, result input, result SRAM writes)   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tpu_seq_ctrl #(
  parameter int ARRAY_SIZE = tpu_pkg::ARRAY_SIZE,
  parameter int BATCHES    = 3,
  parameter int GROUP_LAG  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic           clk,
  input  logic           srstn,
  tpu_seq_ctrl_if.master bus
);
  import tpu_pkg::*;

  // Group 0 reads for c_feed_span cycles; group 1 the same span, GROUP_LAG later.
  localparam int c_feed_span = ARRAY_SIZE * BATCHES + 3;
  localparam int c_feed_last = c_feed_span + GROUP_LAG - 1;
  localparam int c_cnt_w     = $clog2(c_feed_last + 2);
  localparam int c_wait_w    = $clog2(TIMEOUT + 1);

  tpu_state_e          r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_wait_w-1:0] r_wait;
  logic [RADDR_W-1:0]  r_raddr_g0;
  logic [RADDR_W-1:0]  r_raddr_g1;
  logic                r_feed_valid0;
  logic                r_feed_valid1;
  logic                r_array_clear;
  logic                r_done;
  logic                r_busy;
  logic                r_err;

  logic                w_wb_done;
  int unsigned         w_cnt_now;
  int unsigned         w_cnt_next;

  assign w_cnt_now  = 32'(r_cnt);
  assign w_cnt_next = w_cnt_now + 32'd1;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_wait        <= '0;
      r_raddr_g0    <= '0;
      r_raddr_g1    <= '0;
      r_feed_valid0 <= 1'b0;
      r_feed_valid1 <= 1'b0;
      r_array_clear <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_array_clear <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.tpu_start) begin
            r_state       <= ST_FEED;
            r_cnt         <= '0;
            r_wait        <= '0;
            r_err         <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b1;
            r_array_clear <= 1'b1;
            r_raddr_g0    <= lag_addr(0, 0, c_feed_span);
            r_raddr_g1    <= lag_addr(0, GROUP_LAG, c_feed_span);
            r_feed_valid0 <= 1'b0;
            r_feed_valid1 <= 1'b0;
          end
        end

        ST_FEED: begin
          // Address issued this cycle returns from SRAM next cycle.
          r_feed_valid0 <= in_window(w_cnt_now, 0, c_feed_span);
          r_feed_valid1 <= in_window(w_cnt_now, GROUP_LAG, c_feed_span);
          r_raddr_g0    <= lag_addr(w_cnt_next, 0, c_feed_span);
          r_raddr_g1    <= lag_addr(w_cnt_next, GROUP_LAG, c_feed_span);
          r_cnt         <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_w'(c_feed_last)) begin
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          r_feed_valid0 <= 1'b0;
          r_feed_valid1 <= 1'b0;
          r_raddr_g0    <= '0;
          r_raddr_g1    <= '0;
          if (w_wb_done) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_wait == c_wait_w'(TIMEOUT - 1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic [NUM_RES_SRAM-1:0]              w_wsb;
  logic [NUM_RES_SRAM-1:0][WADDR_W-1:0] w_waddr;
  logic [NUM_RES_SRAM-1:0][RES_W-1:0]   w_wdata;

  // r_busy is high exactly during FEED/WAIT, which is when results count.
  tpu_wb_router #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .BATCHES    (BATCHES)
  ) u_wb_router (
    .clk       (clk),
    .srstn     (srstn),
    .active    (r_busy),
    .res_valid (bus.res_valid),
    .res_data  (bus.res_data),
    .wb_done   (w_wb_done),
    .wsb       (w_wsb),
    .waddr     (w_waddr),
    .wdata     (w_wdata)
  );

  assign bus.sram_raddr_w0        = r_raddr_g0;
  assign bus.sram_raddr_d0        = r_raddr_g0;
  assign bus.sram_raddr_w1        = r_raddr_g1;
  assign bus.sram_raddr_d1        = r_raddr_g1;
  assign bus.feed_valid0          = r_feed_valid0;
  assign bus.feed_valid1          = r_feed_valid1;
  assign bus.array_clear          = r_array_clear;
  assign bus.tpu_done             = r_done;
  assign bus.busy                 = r_busy;
  assign bus.err                  = r_err;
  assign bus.sram_write_enable_a0 = w_wsb[0];
  assign bus.sram_write_enable_b0 = w_wsb[1];
  assign bus.sram_write_enable_c0 = w_wsb[2];
  assign bus.sram_waddr_a         = w_waddr[0];
  assign bus.sram_waddr_b         = w_waddr[1];
  assign bus.sram_waddr_c         = w_waddr[2];
  assign bus.sram_wdata_a         = w_wdata[0];
  assign bus.sram_wdata_b         = w_wdata[1];
  assign bus.sram_wdata_c         = w_wdata[2];

endmodule
`default_nettype wire

// File: doc/tpu_seq_ctrl.md
TPU_SEQ_CTRL -- requirements
Module: tpu_seq_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8: systolic array dimension.
REQ-002 SHALL have parameter BATCHES, default 3: matrix pairs per run.
REQ-003 SHALL have parameter GROUP_LAG, default 4: cycle lag of SRAM group 1 (rows 4-7) behind group 0.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum WAIT-state cycles.
REQ-005 SHALL have ports clk (in, 1, clock) and srstn (in, 1, reset; one clock, reset asynchronous active-low).
REQ-006 SHALL have tpu_start (in, 1, one-cycle start pulse).
REQ-007 SHALL have sram_raddr_w0, sram_raddr_w1, sram_raddr_d0, sram_raddr_d1 (out, 10 each, operand SRAM read addresses).
REQ-008 SHALL have feed_valid0 and feed_valid1 (out, 1 each, group 0/1 operand data valid at the array this cycle).
REQ-009 SHALL have array_clear (out, 1, accumulator clear pulse).
REQ-010 SHALL have res_valid (in, 1) and res_data (in, 128): one anti-diagonal result word from the array.
REQ-011 SHALL have sram_write_enable_a0, sram_write_enable_b0, sram_write_enable_c0 (out, 1 each, active-low write strobes for result SRAMs c0/c1/c2).
REQ-012 SHALL have sram_wdata_a/b/c (out, 128 each) and sram_waddr_a/b/c (out, 6 each).
REQ-013 SHALL have tpu_done (out, 1, level), busy (out, 1) and err (out, 1, timeout flag).

Function
REQ-014 SHALL use states IDLE, FEED, WAIT and DONE.
REQ-015 IDLE/DONE -> FEED on tpu_start; entry SHALL clear all counters and err, and pulse array_clear for the first FEED cycle.
REQ-016 FEED SHALL run counter cnt 0..ARRAY_SIZE*BATCHES+3+GROUP_LAG-1 (0..30 at defaults); FEED -> WAIT after cnt = 30.
REQ-017 Group 0 (w0,d0) SHALL get raddr = cnt while cnt < 27, else 0.
REQ-018 Group 1 (w1,d1) SHALL get raddr = cnt-GROUP_LAG while GROUP_LAG <= cnt < 27+GROUP_LAG, else 0.
REQ-019 feed_validN SHALL assert exactly one cycle after its group's address is in range (SRAM read latency 1).
REQ-020 Write-back counter wb SHALL count 0..44 (BATCHES*(2*ARRAY_SIZE-1)), independent of FSM state in FEED/WAIT; batch = wb/15, addr = wb%15.
REQ-021 Each accepted res_valid SHALL produce, one cycle later, wsb=0 on the SRAM of that batch only (c0/c1/c2), with waddr = addr and wdata = res_data; the other two strobes SHALL stay 1.
REQ-022 res_valid SHALL be ignored in IDLE/DONE and after wb has reached 45.
REQ-023 WAIT -> DONE in the cycle after the 45th write is issued.
REQ-024 WAIT -> DONE with err=1 after TIMEOUT WAIT cycles without completion.
REQ-025 tpu_done SHALL be 1 only in DONE; busy SHALL be 1 in FEED/WAIT.
REQ-026 tpu_start SHALL be ignored in FEED/WAIT.
REQ-027 Inactive wdata/waddr outputs SHALL hold their last values.

Reset
REQ-028 Asserting srstn low at any time SHALL immediately force IDLE; all raddr and waddr outputs to 0; wdata to 0; all wsb to 1; and feed_valid, array_clear, tpu_done, busy and err to 0.
REQ-029 A reset during FEED/WAIT SHALL abort the run with no further writes.

Structure
REQ-030 ARRAY_SIZE, the data widths (8/16/128), the SRAM address widths (10/6) and the FSM state enum SHALL live in shared package tpu_pkg.
REQ-031 Write-back routing (wb counter, batch decode, registered strobes) SHALL be sub-module tpu_wb_router.

Verification
REQ-032 Test: start pulse, no res_valid -> raddr_w0 0..26 on cycles 0..26, raddr_w1 0..26 on cycles 4..30, feed_valid0 high cycles 1..27, then err=1 and tpu_done after 255 WAIT cycles.
REQ-033 Test: 45 res_valid pulses with res_data = index -> c0 addrs 0..14 get 0..14, c1 gets 15..29, c2 gets 30..44; tpu_done 1 cycle after the last write; err=0.
REQ-034 Test: a 46th res_valid and res_valid while IDLE -> no wsb low.
REQ-035 Test: srstn low at FEED cnt=10 -> all outputs at reset values asynchronously; a new start then restarts at raddr 0 with wb=0.
REQ-036 Test: tpu_start during WAIT -> ignored; tpu_start in DONE -> tpu_done drops, new run begins with an array_clear pulse.
